// File: rtl/cpu_pkg.sv
// Shared CPU-side constants for the register-file writeback path.
package cpu_pkg;
   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 5;
   localparam int REG_COUNT = 2 ** ADDR_W;

   localparam logic REQ_ALU = 1'b0;
   localparam logic REQ_MEM = 1'b1;
endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Writeback requesters, decode hazard probe and register-file write port bundle.
interface reg_wb_arbiter_if #(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int ADDR_W = cpu_pkg::ADDR_W
) ();
   logic              req0_valid;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;
   logic              issue_valid;
   logic [ADDR_W-1:0] issue_rd;
   logic [ADDR_W-1:0] chk_r1;
   logic [ADDR_W-1:0] chk_r2;
   logic              busy1;
   logic              busy2;
   logic [ADDR_W-1:0] write_reg;
   logic [DATA_W-1:0] write_d;
   logic              reg_write;
   logic              sb_err;

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      input  req1_valid, req1_addr, req1_data,
      input  issue_valid, issue_rd, chk_r1, chk_r2,
      output req0_ready, req1_ready, busy1, busy2,
      output write_reg, write_d, reg_write, sb_err
   );

   modport master (
      output req0_valid, req0_addr, req0_data,
      output req1_valid, req1_addr, req1_data,
      output issue_valid, issue_rd, chk_r1, chk_r2,
      input  req0_ready, req1_ready, busy1, busy2,
      input  write_reg, write_d, reg_write, sb_err
   );
endinterface

// File: rtl/reg_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant; the grant is combinational, last_grant is the only state.
//   state    | meaning
//   LAST_ALU | requester 0 won most recently, requester 1 wins the next tie
//   LAST_MEM | requester 1 won most recently (reset), requester 0 wins the next tie
module rr_arb2
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);
   localparam logic [0:0] LAST_ALU = REQ_ALU;
   localparam logic [0:0] LAST_MEM = REQ_MEM;

   logic [0:0] last_grant;

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last_grant == LAST_MEM) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   // Every grant is a completed transfer because the requester is already valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= LAST_MEM;
      end else if (gnt[0]) begin
         last_grant <= LAST_ALU;
      end else if (gnt[1]) begin
         last_grant <= LAST_MEM;
      end
   end
endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the register-file write port between ALU and load writebacks and tracks
// pending destination registers so decode can see RAW hazards.
module reg_wb_arbiter
   import cpu_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   reg_wb_arbiter_if.slave    bus
);
   logic [1:0]           gnt;
   logic                 accept;
   logic [ADDR_W-1:0]    acc_addr;
   logic [DATA_W-1:0]    acc_data;
   logic [REG_COUNT-1:0] pending;
   logic [REG_COUNT-1:0] pending_nxt;
   logic [ADDR_W-1:0]    write_reg_q;
   logic [DATA_W-1:0]    write_d_q;
   logic                 reg_write_q;
   logic                 sb_err_q;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   ({bus.req1_valid, bus.req0_valid}),
      .gnt   (gnt)
   );

   assign bus.req0_ready = gnt[0];
   assign bus.req1_ready = gnt[1];
   assign accept         = |gnt;
   assign acc_addr       = gnt[1] ? bus.req1_addr : bus.req0_addr;
   assign acc_data       = gnt[1] ? bus.req1_data : bus.req0_data;

   // Set is applied after clear so a re-issue in the commit cycle stays outstanding.
   always_comb begin
      pending_nxt = pending;
      if (accept) begin
         pending_nxt[acc_addr] = 1'b0;
      end
      if (bus.issue_valid && (bus.issue_rd != '0)) begin
         pending_nxt[bus.issue_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending     <= '0;
         write_reg_q <= '0;
         write_d_q   <= '0;
         reg_write_q <= 1'b0;
         sb_err_q    <= 1'b0;
      end else begin
         pending     <= pending_nxt;
         reg_write_q <= accept;
         if (accept) begin
            write_reg_q <= acc_addr;
            write_d_q   <= acc_data;
         end
         if (accept && (acc_addr != '0) && !pending[acc_addr]) begin
            sb_err_q <= 1'b1;
         end
      end
   end

   assign bus.write_reg = write_reg_q;
   assign bus.write_d   = write_d_q;
   assign bus.reg_write = reg_write_q;
   assign bus.sb_err    = sb_err_q;
   assign bus.busy1     = (bus.chk_r1 != '0) && pending[bus.chk_r1];
   assign bus.busy2     = (bus.chk_r2 != '0) && pending[bus.chk_r2];
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed plus randomized bench for reg_wb_arbiter against a behavioural model.
module tb_reg_wb_arbiter;
   import cpu_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   reg_wb_arbiter_if bus ();

   reg_wb_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   bit                m_pending [REG_COUNT];
   int                m_last;
   bit                m_err;
   logic [ADDR_W-1:0] m_wreg;
   logic [DATA_W-1:0] m_wd;
   bit                m_rw;
   int                last_g;
   int                wr_log [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_busy(input logic [ADDR_W-1:0] a);
      return (a != 0) && m_pending[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < REG_COUNT; i++) m_pending[i] = 1'b0;
      m_last = 1;
      m_err  = 1'b0;
      m_wreg = '0;
      m_wd   = '0;
      m_rw   = 1'b0;
   endtask

   task automatic idle_inputs();
      bus.req0_valid  = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
      bus.req1_valid  = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
      bus.issue_valid = 1'b0; bus.issue_rd  = '0;
      bus.chk_r1      = '0;   bus.chk_r2    = '0;
   endtask

   // Called at posedge+1 with inputs already applied; advances one clock.
   task automatic cycle();
      int                g;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      #1;
      g = -1;
      if (bus.req0_valid && bus.req1_valid) g = (m_last == 0) ? 1 : 0;
      else if (bus.req0_valid)              g = 0;
      else if (bus.req1_valid)              g = 1;
      chk("req0_ready", bus.req0_ready, g == 0);
      chk("req1_ready", bus.req1_ready, g == 1);
      chk("busy1_pre", bus.busy1, m_busy(bus.chk_r1));
      chk("busy2_pre", bus.busy2, m_busy(bus.chk_r2));
      a = (g == 1) ? bus.req1_addr : bus.req0_addr;
      d = (g == 1) ? bus.req1_data : bus.req0_data;
      @(posedge clk);
      #1;
      if (g >= 0) begin
         if (a != 0 && !m_pending[a]) m_err = 1'b1;
         m_pending[a] = 1'b0;
         m_wreg = a;
         m_wd   = d;
         m_rw   = 1'b1;
         m_last = g;
      end else begin
         m_rw = 1'b0;
      end
      if (bus.issue_valid && bus.issue_rd != 0) m_pending[bus.issue_rd] = 1'b1;
      last_g = g;
      chk("reg_write", bus.reg_write, m_rw);
      chk("write_reg", bus.write_reg, m_wreg);
      chk("write_d",   bus.write_d,   m_wd);
      chk("sb_err",    bus.sb_err,    m_err);
      chk("busy1",     bus.busy1,     m_busy(bus.chk_r1));
      chk("busy2",     bus.busy2,     m_busy(bus.chk_r2));
      if (bus.reg_write) wr_log.push_back(int'(bus.write_reg));
   endtask

   // Asserts reset mid-cycle, checks the immediate clear, holds across an edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_reg_write", bus.reg_write, 0);
      chk("rst_write_reg", bus.write_reg, 0);
      chk("rst_write_d",   bus.write_d,   0);
      chk("rst_sb_err",    bus.sb_err,    0);
      chk("rst_busy1",     bus.busy1,     0);
      chk("rst_busy2",     bus.busy2,     0);
      idle_inputs();
      @(posedge clk);
      #1;
      chk("rst_hold_reg_write", bus.reg_write, 0);
      rst_n = 1'b1;
   endtask

   initial begin
      int exp_seq [8] = '{1, 9, 2, 10, 3, 11, 4, 12};
      int i0, i1, guard, wait0, wait1;
      bit hold0, hold1;

      idle_inputs();
      model_reset();
      #3;
      chk("init_reg_write", bus.reg_write, 0);
      chk("init_write_reg", bus.write_reg, 0);
      chk("init_sb_err",    bus.sb_err,    0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) cycle();

      // Single write through the ALU port.
      bus.issue_valid = 1'b1; bus.issue_rd = 5; bus.chk_r1 = 5;
      cycle();
      chk("single_busy_set", bus.busy1, 1);
      bus.issue_valid = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_addr = 5; bus.req0_data = 32'hDEAD_BEEF;
      cycle();
      bus.req0_valid = 1'b0;
      chk("single_write_reg", bus.write_reg, 5);
      chk("single_write_d",   bus.write_d,   32'hDEAD_BEEF);
      chk("single_busy_clr",  bus.busy1,     0);
      do_reset();

      // Contention: both requesters active, alternate from reset (last_grant=1).
      foreach (exp_seq[k]) begin
         bus.issue_valid = 1'b1; bus.issue_rd = exp_seq[k][ADDR_W-1:0];
         cycle();
      end
      bus.issue_valid = 1'b0;
      wr_log.delete();
      i0 = 0; i1 = 0; guard = 0;
      while ((i0 < 4 || i1 < 4) && guard < 20) begin
         bus.req0_valid = (i0 < 4); bus.req0_addr = ADDR_W'(1 + i0); bus.req0_data = 32'hA000_0000 + i0;
         bus.req1_valid = (i1 < 4); bus.req1_addr = ADDR_W'(9 + i1); bus.req1_data = 32'hB000_0000 + i1;
         cycle();
         if (last_g == 0) i0++;
         else if (last_g == 1) i1++;
         guard++;
      end
      idle_inputs();
      chk("contention_done", guard < 20, 1);
      chk("contention_len", wr_log.size(), 8);
      for (int k = 0; k < 8 && k < wr_log.size(); k++) chk("contention_seq", wr_log[k], exp_seq[k]);
      chk("contention_no_err", bus.sb_err, 0);

      // Set and clear of the same register at one edge.
      bus.issue_valid = 1'b1; bus.issue_rd = 7; bus.chk_r1 = 7;
      cycle();
      bus.req1_valid = 1'b1; bus.req1_addr = 7; bus.req1_data = 32'h0000_0077;
      cycle();
      idle_inputs(); bus.chk_r1 = 7;
      chk("collision_busy", bus.busy1, 1);
      chk("collision_no_err", bus.sb_err, 0);
      bus.req0_valid = 1'b1; bus.req0_addr = 7; bus.req0_data = 32'h0000_0707;
      cycle();
      bus.req0_valid = 1'b0;
      chk("collision_clear", bus.busy1, 0);

      // Commit with nothing pending, then r0 probing.
      bus.req0_valid = 1'b1; bus.req0_addr = 3; bus.req0_data = 32'h3333_3333;
      cycle();
      bus.req0_valid = 1'b0;
      chk("err_write_reg", bus.write_reg, 3);
      chk("err_set", bus.sb_err, 1);
      cycle();
      chk("err_sticky", bus.sb_err, 1);
      bus.issue_valid = 1'b1; bus.issue_rd = 0; bus.chk_r1 = 0;
      cycle();
      bus.issue_valid = 1'b0;
      chk("r0_busy", bus.busy1, 0);

      // Randomized traffic with requesters holding until accepted.
      hold0 = 1'b0; hold1 = 1'b0; wait0 = 0; wait1 = 0;
      for (int n = 0; n < 300; n++) begin
         if (!hold0) begin
            bus.req0_valid = 1'($urandom_range(0, 1));
            bus.req0_addr  = ADDR_W'($urandom_range(0, 7));
            bus.req0_data  = $urandom;
         end
         if (!hold1) begin
            bus.req1_valid = 1'($urandom_range(0, 1));
            bus.req1_addr  = ADDR_W'($urandom_range(0, 7));
            bus.req1_data  = $urandom;
         end
         bus.issue_valid = 1'($urandom_range(0, 1));
         bus.issue_rd    = ADDR_W'($urandom_range(0, 7));
         bus.chk_r1      = ADDR_W'($urandom_range(0, 7));
         bus.chk_r2      = ADDR_W'($urandom_range(0, 7));
         cycle();
         hold0 = bus.req0_valid && last_g != 0;
         hold1 = bus.req1_valid && last_g != 1;
         wait0 = hold0 ? wait0 + 1 : 0;
         wait1 = hold1 ? wait1 + 1 : 0;
         chk("starve0", wait0 > 1, 0);
         chk("starve1", wait1 > 1, 0);
      end
      idle_inputs();
      cycle();

      // Reset while a request is being granted: nothing may come out.
      bus.issue_valid = 1'b1; bus.issue_rd = 6;
      cycle();
      bus.issue_valid = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_addr = 6; bus.req0_data = 32'h6666_6666;
      bus.chk_r1 = 6;
      #1;
      chk("flight_ready", bus.req0_ready, 1);
      chk("flight_busy", bus.busy1, 1);
      do_reset();
      bus.chk_r1 = 6;
      cycle();
      chk("flight_no_pulse", bus.reg_write, 0);
      chk("flight_pending_clr", bus.busy1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
